// File: rtl/phase_counter_pkg.sv
// Shared types and default constants for the phase counter scheduler.
// Two requesters share one x/y counter pair that runs a fixed two-phase job.
package phase_counter_pkg;

  localparam int DEF_W       = 11;
  localparam int DEF_X_KNEE  = 100;
  localparam int DEF_X_LIMIT = 200;
  localparam int DEF_Y_INIT  = 100;
  localparam int DEF_Y_LIMIT = 200;

  // The low two bits form the external phase code; DONE aliases IDLE there
  // and is told apart by busy being high.
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_PHASE_A = 3'd2,
    ST_PHASE_B = 3'd3,
    ST_DONE    = 3'd4
  } state_e;

  function automatic logic [1:0] onehot2(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/phase_counter_sched_if.sv
// Requester-facing signal bundle of phase_counter_sched.
// Handshake: a requester raises req[i] and holds it high until done[i] pulses;
// grant[i] stays high from LOAD through DONE; dropping req[i] early aborts the job.
interface phase_counter_sched_if
  import phase_counter_pkg::*;
#(
  parameter int W = DEF_W
);
  logic [1:0]   req;
  logic         hold;
  logic [1:0]   grant;
  logic [1:0]   done;
  logic         busy;
  logic [1:0]   phase;
  logic [W-1:0] x;
  logic [W-1:0] y;
  logic         inv_err;
  logic         rr_ptr;

  modport master (
    output req, hold,
    input  grant, done, busy, phase, x, y, inv_err, rr_ptr
  );

  modport slave (
    input  req, hold,
    output grant, done, busy, phase, x, y, inv_err, rr_ptr
  );
endinterface

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter: ptr names the requester preferred next.
// advance moves the preference to the requester that was not just served.
module rr_arb2
  import phase_counter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic [1:0] grant,
  output logic       ptr
);
  logic ptr_q, ptr_d;
  logic other;

  assign other = ~ptr_q;
  assign ptr   = ptr_q;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) ptr_d = ~served;
  end

  always_comb begin
    grant = 2'b00;
    if (req[ptr_q])      grant = onehot2(ptr_q);
    else if (req[other]) grant = onehot2(other);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end
endmodule

// File: rtl/phase_counter_sched.sv
// Grants the shared x/y counter pair to one requester and runs LOAD, PHASE_A
// (x counts to X_KNEE) and PHASE_B (x counts to X_LIMIT, y saturates at Y_LIMIT).
module phase_counter_sched
  import phase_counter_pkg::*;
#(
  parameter int W       = DEF_W,
  parameter int X_KNEE  = DEF_X_KNEE,
  parameter int X_LIMIT = DEF_X_LIMIT,
  parameter int Y_INIT  = DEF_Y_INIT,
  parameter int Y_LIMIT = DEF_Y_LIMIT
) (
  input logic                  clk,
  input logic                  rst,
  phase_counter_sched_if.slave bus
);
  if (X_KNEE <= 0 || X_KNEE >= X_LIMIT || X_LIMIT >= (1 << W)) begin : g_bad_x
    $error("phase_counter_sched: require 0 < X_KNEE < X_LIMIT < 2**W");
  end
  if (Y_INIT < 0 || Y_INIT > Y_LIMIT || Y_LIMIT >= (1 << W)) begin : g_bad_y
    $error("phase_counter_sched: require Y_INIT <= Y_LIMIT < 2**W");
  end

  localparam logic [W-1:0] XK_LAST = W'(X_KNEE - 1);
  localparam logic [W-1:0] XL_LAST = W'(X_LIMIT - 1);
  localparam logic [W-1:0] XL      = W'(X_LIMIT);
  localparam logic [W-1:0] YI      = W'(Y_INIT);
  localparam logic [W-1:0] YL      = W'(Y_LIMIT);
  localparam logic [W-1:0] ONE     = W'(1);

  state_e       state_q, state_d;
  logic [1:0]   grant_q, grant_d;
  logic [1:0]   done_q, done_d;
  logic [W-1:0] x_q, x_d;
  logic [W-1:0] y_q, y_d;
  logic         inv_q, inv_d;
  logic [1:0]   arb_grant;
  logic         arb_ptr;
  logic         advance;
  logic         abort;
  logic         owner_req;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst),
    .req     (bus.req),
    .advance (advance),
    .served  (grant_q[1]),
    .grant   (arb_grant),
    .ptr     (arb_ptr)
  );

  assign owner_req = |(bus.req & grant_q);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    done_d  = 2'b00;
    x_d     = x_q;
    y_d     = y_q;
    advance = 1'b0;
    abort   = 1'b0;
    inv_d   = inv_q | ((state_q != ST_LOAD) && (x_q >= XL) && (y_q != YL));

    case (state_q)
      ST_IDLE: begin
        if (|arb_grant) begin
          state_d = ST_LOAD;
          grant_d = arb_grant;
        end
      end
      ST_LOAD: begin
        if (!owner_req) abort = 1'b1;
        else begin
          x_d     = '0;
          y_d     = YI;
          state_d = ST_PHASE_A;
        end
      end
      ST_PHASE_A: begin
        if (!owner_req) abort = 1'b1;
        else if (!bus.hold) begin
          x_d = x_q + ONE;
          if (x_q == XK_LAST) state_d = ST_PHASE_B;
        end
      end
      ST_PHASE_B: begin
        if (!owner_req) abort = 1'b1;
        else if (!bus.hold) begin
          x_d = x_q + ONE;
          if (y_q < YL) y_d = y_q + ONE;
          if (x_q == XL_LAST) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_d  = grant_q;
        grant_d = 2'b00;
        advance = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // An abandoned job releases the counters but leaves x/y as they were.
    if (abort) begin
      state_d = ST_IDLE;
      grant_d = 2'b00;
      advance = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= 2'b00;
      done_q  <= 2'b00;
      x_q     <= '0;
      y_q     <= YI;
      inv_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      done_q  <= done_d;
      x_q     <= x_d;
      y_q     <= y_d;
      inv_q   <= inv_d;
    end
  end

  assign bus.grant   = grant_q;
  assign bus.done    = done_q;
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.phase   = state_q[1:0];
  assign bus.x       = x_q;
  assign bus.y       = y_q;
  assign bus.inv_err = inv_q;
  assign bus.rr_ptr  = arb_ptr;
endmodule
